mem_port_arbiter: RTL and testbench

Controller and arbiter that shares one single-ported 64-bit data memory between the instruction-fetch path and the load/store path of the multicycle core. It accepts requests from both, serialises them with data priority plus a fetch starvation guard, and drives the memory's address, write-data and write-enable for each access. For reads it waits out the memory's fixed read latency and returns the word to the winning requester.

---
 rtl/mem_arb_pkg.sv | 5 +
 rtl/mem_arb_starve_ctr.sv | 19 +
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner types for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;
  typedef enum logic {OWN_IF, OWN_D} ownerT;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants taken while fetch waits
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(STARVE_MAX + 1);
  logic [W-1:0] cnt;
  assign sat = cnt == W'(STARVE_MAX);
  // clear wins over increment; the count sticks once it reaches the limit
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 64-bit memory between fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_wr,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(MEM_LAT + 1);
  stateT state, nextState;
  ownerT owner, winner;
  logic [ADDR_W-1:0] addrQ;
  logic weQ;
  logic [63:0] wdataQ;
  logic [CW-1:0] waitCnt;
  logic sample, starveSat, lastWait, unusedAddrBits;
  assign sample = state == IDLE && (if_req || d_req);
  assign winner = (d_req && !(if_req && starveSat)) ? OWN_D : OWN_IF;
  assign lastWait = state == WAIT && waitCnt == CW'(1);
  assign unusedAddrBits = ^addrQ[1:0];
  // next state: stores finish right after ISSUE, reads wait out the memory latency
  always_comb
    nextState = state == IDLE  ? (sample ? ISSUE : IDLE) :
                state == ISSUE ? ((owner == OWN_D && weQ) ? IDLE : WAIT) :
                state == WAIT  ? (lastWait ? RESP : WAIT) : IDLE;
  // state, request latches, latency counter and per-owner read data capture
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      owner <= OWN_IF;
      addrQ <= '0;
      weQ <= 1'b0;
      wdataQ <= '0;
      waitCnt <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= nextState;
      if (sample) begin
        owner <= winner;
        addrQ <= winner == OWN_D ? d_addr : if_addr;
        weQ <= winner == OWN_D && d_we;
        if (winner == OWN_D) wdataQ <= d_wdata;
      end
      if (state == ISSUE) waitCnt <= CW'(MEM_LAT);
      else if (state == WAIT) waitCnt <= waitCnt - 1'b1;
      if (lastWait && owner == OWN_IF) if_rdata <= addrQ[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      if (lastWait && owner == OWN_D) d_rdata <= mem_rdata;
    end
  assign if_gnt = state == ISSUE && owner == OWN_IF;
  assign d_gnt = state == ISSUE && owner == OWN_D;
  assign if_rvalid = state == RESP && owner == OWN_IF;
  assign d_rvalid = state == RESP && owner == OWN_D;
  assign mem_wr = d_gnt && weQ;
  assign mem_addr = {addrQ[ADDR_W-1:3], 3'b000};
  assign mem_wdata = wdataQ;
  assign busy = state != IDLE;
  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(Clk),
    .rst(Reset),
    .inc(d_gnt && if_req),
    .clr(if_gnt || (state == IDLE && !if_req)),
    .sat(starveSat)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  typedef struct {int kind; int cyc; logic [63:0] addr; logic [63:0] data; logic wr;} evT;
  logic Clk = 1'b0, Reset;
  logic if_req, d_req, d_we, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wr, busy;
  logic [63:0] if_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata, p1, p2;
  logic [31:0] if_rdata;
  logic d1Req, if1Gnt, if1Rvalid, d1Gnt, d1Rvalid, mem1Wr, busy1;
  logic [63:0] d1Addr, d1Rdata, mem1Addr, mem1Wdata, q1;
  logic [31:0] if1Rdata;
  int cyc = 0, checks = 0, failures = 0, k;
  evT sb[$];
  evT e;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
  );
  mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .if_req(1'b0), .if_addr(64'h0), .if_gnt(if1Gnt), .if_rvalid(if1Rvalid), .if_rdata(if1Rdata),
    .d_req(d1Req), .d_we(1'b0), .d_addr(d1Addr), .d_wdata(64'h0),
    .d_gnt(d1Gnt), .d_rvalid(d1Rvalid), .d_rdata(d1Rdata),
    .mem_addr(mem1Addr), .mem_wdata(mem1Wdata), .mem_wr(mem1Wr), .mem_rdata(q1), .busy(busy1)
  );
  function automatic logic [63:0] memWord(input logic [63:0] a);
    return a == 64'h100 ? 64'hAAAA_BBBB_1111_2222 : {~a[31:0], a[31:0] ^ 32'h5A5A_0000};
  endfunction
  function automatic logic [63:0] expData(input bit isIf, input logic [63:0] a);
    logic [63:0] w;
    w = memWord(a & ~64'h7);
    return isIf ? {32'h0, a[2] ? w[63:32] : w[31:0]} : w;
  endfunction
  // memory model: read data appears MEM_LAT cycles after the address
  always @(posedge Clk) begin
    p1 <= memWord(mem_addr);
    p2 <= p1;
    q1 <= memWord(mem1Addr);
  end
  assign mem_rdata = p2;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", n, cyc, act, exp);
    end
  endtask
  function automatic void push(input int kd, input int c, input logic [63:0] a, input logic [63:0] d, input logic w);
    sb.push_back('{kd, c, a, d, w});
  endfunction
  task automatic allZero(input string t);
    chk({t, "_if_gnt"}, if_gnt, 0);
    chk({t, "_if_rvalid"}, if_rvalid, 0);
    chk({t, "_if_rdata"}, if_rdata, 0);
    chk({t, "_d_gnt"}, d_gnt, 0);
    chk({t, "_d_rvalid"}, d_rvalid, 0);
    chk({t, "_d_rdata"}, d_rdata, 0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_mem_wdata"}, mem_wdata, 0);
    chk({t, "_mem_wr"}, mem_wr, 0);
    chk({t, "_busy"}, busy, 0);
  endtask
  task automatic access(input bit isIf, input bit we, input logic [63:0] a, input logic [63:0] wd);
    int c;
    bit st;
    c = cyc;
    st = !isIf && we;
    if (isIf) begin if_req = 1; if_addr = a; end
    else begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    push(isIf ? 0 : 1, c + 1, a & ~64'h7, wd, st);
    if (!st) push(isIf ? 2 : 3, c + MEM_LAT + 2, 0, expData(isIf, a), 0);
    @(negedge Clk);
    if_req = 0;
    d_req = 0;
    while (cyc < c + (st ? 2 : MEM_LAT + 3)) @(negedge Clk);
  endtask
  // monitor: every grant, rvalid or write must match the oldest expected event
  always @(negedge Clk)
    if (if_gnt || d_gnt || if_rvalid || d_rvalid || mem_wr) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event cycle=%0d gnt=%b%b rvalid=%b%b wr=%b expected none", cyc, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wr);
      end else begin
        e = sb.pop_front();
        k = if_gnt ? 0 : d_gnt ? 1 : if_rvalid ? 2 : d_rvalid ? 3 : 4;
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (e.kind < 2) begin
          chk("grant_mem_addr", mem_addr, e.addr);
          chk("grant_mem_wr", mem_wr, e.wr);
          if (e.wr) chk("store_wdata", mem_wdata, e.data);
        end else chk("rdata", e.kind == 2 ? {32'h0, if_rdata} : d_rdata, e.data);
      end
    end
  initial begin
    int c;
    Reset = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    d1Req = 0; d1Addr = 0;
    repeat (3) @(negedge Clk);
    allZero("reset");
    Reset = 0;
    @(negedge Clk);
    access(1, 0, 64'h104, 0);
    access(0, 1, 64'h20, 64'hDEAD);
    chk("store_busy_low", busy, 0);
    chk("store_wr_low", mem_wr, 0);
    chk("store_no_drdata", d_rdata, 0);
    access(0, 0, 64'h40, 0);
    chk("if_rdata_hold", if_rdata, 64'hAAAA_BBBB);
    access(1, 0, 64'h100, 0);
    access(0, 1, 64'h80, 64'h1234);
    access(0, 1, 64'h88, 64'h5678);
    c = cyc;
    if_req = 1; if_addr = 64'h10C; d_req = 1; d_we = 0; d_addr = 64'h48;
    for (int i = 0; i < 6; i++) begin
      push(i == 4 ? 0 : 1, c + 5 * i + 1, i == 4 ? 64'h108 : 64'h48, 0, 0);
      push(i == 4 ? 2 : 3, c + 5 * i + 4, 0, expData(i == 4, i == 4 ? 64'h10C : 64'h48), 0);
    end
    while (cyc < c + 26) @(negedge Clk);
    if_req = 0; d_req = 0;
    while (cyc < c + 30) @(negedge Clk);
    c = cyc;
    if_req = 1; if_addr = 64'h64; d_req = 1; d_we = 0; d_addr = 64'h50;
    push(1, c + 1, 64'h50, 0, 0);
    push(3, c + 4, 0, expData(0, 64'h50), 0);
    push(0, c + 6, 64'h60, 0, 0);
    push(2, c + 9, 0, expData(1, 64'h64), 0);
    @(negedge Clk);
    d_req = 0;
    while (cyc < c + 6) @(negedge Clk);
    if_req = 0;
    while (cyc < c + 10) @(negedge Clk);
    c = cyc;
    d_req = 1; d_we = 0; d_addr = 64'h58;
    push(1, c + 1, 64'h58, 0, 0);
    @(negedge Clk);
    d_req = 0;
    @(negedge Clk);
    Reset = 1;
    #1 allZero("reset_mid");
    @(negedge Clk);
    Reset = 0;
    repeat (6) @(negedge Clk);
    access(0, 0, 64'h60, 0);
    d1Req = 1; d1Addr = 64'h70;
    @(negedge Clk);
    chk("lat1_gnt", d1Gnt, 1);
    d1Req = 0;
    @(negedge Clk);
    chk("lat1_rvalid_early", d1Rvalid, 0);
    @(negedge Clk);
    chk("lat1_rvalid", d1Rvalid, 1);
    chk("lat1_rdata", d1Rdata, memWord(64'h70));
    @(negedge Clk);
    chk("lat1_idle", busy1, 0);
    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
